// File: rtl/cmd_buffer_pkg.sv
// Shared types and defaults for the SPI command latch buffer.
package cmd_buffer_pkg;

    localparam int CMD_WIDTH     = 32;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_LATCH_GAP = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        LATCH   = 2'd2,
        GAP     = 2'd3
    } state_t;

endpackage

// File: rtl/cmd_latch_buffer_sync_fifo.sv
// Synchronous FIFO with level tracking; full/empty are derived from the level.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  empty,
    output logic                  full
);

    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = DEPTH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty   = (level == '0);
    assign full    = (level == FULL_LEVEL);
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers and level define validity.
    always_ff @(posedge clock) begin
        if (do_push && !reset && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/cmd_latch_buffer.sv
// Buffers SPI command words and hands them to the controller as spaced,
// single-cycle latch strobes with a one-cycle setup before each strobe.
module cmd_latch_buffer
    import cmd_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = CMD_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = 3,
    parameter int LATCH_GAP  = DEF_LATCH_GAP
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic                  hold,
    output logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  latch_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
);

    localparam logic [7:0] GAP_LOAD = 8'(LATCH_GAP - 1);

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            gap_cnt;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  push;
    logic                  pop;

    // A push in the flush cycle is discarded along with the FIFO contents.
    assign push     = in_valid && !full && !flush;
    assign pop      = (state == LATCH) && !flush;
    assign in_ready = !full;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush   (flush),
        .push    (push),
        .wr_data (in_data),
        .pop     (pop),
        .rd_data (head_data),
        .level   (level),
        .empty   (empty),
        .full    (full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty && !hold) state_nxt = PRESENT;
            PRESENT: state_nxt = LATCH;
            LATCH:   state_nxt = GAP;
            GAP:     if (gap_cnt == 8'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    // cmd_data is only reloaded on IDLE->PRESENT so it stays stable through
    // the setup, strobe and gap; flush keeps the last presented word.
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_data   <= '0;
            latch_data <= 1'b0;
            gap_cnt    <= 8'd0;
            overflow   <= 1'b0;
        end else if (flush) begin
            latch_data <= 1'b0;
            gap_cnt    <= 8'd0;
            overflow   <= 1'b0;
        end else begin
            latch_data <= (state_nxt == LATCH);
            if (state == IDLE && state_nxt == PRESENT) begin
                cmd_data <= head_data;
            end
            if (state == LATCH) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == GAP && gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
            if (in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
